// File: rtl/control_carrera.sv
// Race sequencer for the line-follower stopwatch: conditions the arm/start/finish inputs,
// drives the cronometro reset/enable lines and latches the final race time.
//
// state   | meaning
// IDLE    | after reset, timer held cleared, waiting for arm
// ARMED   | timer held cleared, waiting for start-line pulse
// RUNNING | timer counting, waiting for finish (after lockout) or timeout
// DONE    | timer frozen, final time latched
module control_carrera #(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int MIN_LAP_S   = 3,
  parameter int TIMEOUT_MIN = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_arm,
  input  logic       sensor_start,
  input  logic       sensor_finish,
  input  logic [5:0] segundos,
  input  logic [3:0] minutos,
  output logic       reset_timer,
  output logic       enable_timer,
  output logic [5:0] final_seg,
  output logic [3:0] final_min,
  output logic       final_valid,
  output logic       timeout,
  output logic [1:0] estado
);

  localparam int DEB_CYC = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] DEB_RELOAD = CW'(DEB_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUNNING = 2'd2, DONE = 2'd3} state_t;

  // Bit 0 arm, bit 1 start, bit 2 finish.
  logic [2:0] raw;
  logic [2:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0] deb_q, deb_d, pulse_q, pulse_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  assign raw = {sensor_finish, sensor_start, btn_arm};

  // Down-counter reloads whenever the synced level agrees with the debounced one;
  // terminal count on a disagreeing sample commits the new level.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    pulse_d = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = DEB_RELOAD;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == '0) begin
          deb_d[i]   = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end
      end
    end
  end

  state_t     state_q, state_d;
  logic       reset_timer_q, reset_timer_d;
  logic       enable_timer_q, enable_timer_d;
  logic [5:0] final_seg_q, final_seg_d;
  logic [3:0] final_min_q, final_min_d;
  logic       final_valid_q, final_valid_d;
  logic       timeout_q, timeout_d;
  logic [9:0] elapsed;

  assign elapsed = ({6'd0, minutos} * 10'd60) + {4'd0, segundos};

  always_comb begin
    state_d       = state_q;
    final_seg_d   = final_seg_q;
    final_min_d   = final_min_q;
    final_valid_d = final_valid_q;
    timeout_d     = timeout_q;
    if (pulse_q[0]) begin
      state_d       = ARMED;
      final_valid_d = 1'b0;
      timeout_d     = 1'b0;
    end else begin
      case (state_q)
        ARMED: if (pulse_q[1]) state_d = RUNNING;
        RUNNING: begin
          if (minutos == 4'(TIMEOUT_MIN) && segundos == 6'd0) begin
            state_d       = DONE;
            timeout_d     = 1'b1;
            final_seg_d   = segundos;
            final_min_d   = minutos;
            final_valid_d = 1'b1;
          end else if (pulse_q[2] && elapsed >= 10'(MIN_LAP_S)) begin
            state_d       = DONE;
            timeout_d     = 1'b0;
            final_seg_d   = segundos;
            final_min_d   = minutos;
            final_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    reset_timer_d  = (state_d == IDLE) || (state_d == ARMED);
    enable_timer_d = (state_d == RUNNING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      deb_q          <= '0;
      pulse_q        <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= DEB_RELOAD;
      state_q        <= IDLE;
      reset_timer_q  <= 1'b1;
      enable_timer_q <= 1'b0;
      final_seg_q    <= '0;
      final_min_q    <= '0;
      final_valid_q  <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      deb_q          <= deb_d;
      pulse_q        <= pulse_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q        <= state_d;
      reset_timer_q  <= reset_timer_d;
      enable_timer_q <= enable_timer_d;
      final_seg_q    <= final_seg_d;
      final_min_q    <= final_min_d;
      final_valid_q  <= final_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  assign reset_timer  = reset_timer_q;
  assign enable_timer = enable_timer_q;
  assign final_seg    = final_seg_q;
  assign final_min    = final_min_q;
  assign final_valid  = final_valid_q;
  assign timeout      = timeout_q;
  assign estado       = state_q;

endmodule

// File: tb/tb_control_carrera.sv
// Bench for control_carrera: a stand-in stopwatch (one second every TICK cycles), a
// behavioural reference model checked every cycle, table-driven steps and directed races.
module tb_control_carrera;
  localparam int CLK_FREQ    = 1000;
  localparam int DEBOUNCE_MS = 10;
  localparam int MIN_LAP_S   = 3;
  localparam int TIMEOUT_MIN = 9;
  localparam int DEB_CYC     = 10;
  localparam int TICK        = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_arm = 1'b0, sensor_start = 1'b0, sensor_finish = 1'b0;
  logic [5:0] t_seg = '0;
  logic [3:0] t_min = '0;
  int t_tick = 0;
  logic reset_timer, enable_timer, final_valid, timeout;
  logic [5:0] final_seg;
  logic [3:0] final_min;
  logic [1:0] estado;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  control_carrera #(
    .CLK_FREQ(CLK_FREQ), .DEBOUNCE_MS(DEBOUNCE_MS),
    .MIN_LAP_S(MIN_LAP_S), .TIMEOUT_MIN(TIMEOUT_MIN)
  ) dut (
    .clk(clk), .reset(reset), .btn_arm(btn_arm), .sensor_start(sensor_start),
    .sensor_finish(sensor_finish), .segundos(t_seg), .minutos(t_min),
    .reset_timer(reset_timer), .enable_timer(enable_timer), .final_seg(final_seg),
    .final_min(final_min), .final_valid(final_valid), .timeout(timeout), .estado(estado)
  );

  always #5 clk = ~clk;

  // Reference model state: 0 idle, 1 armed, 2 running, 3 done.
  int m_state = 0;
  bit m_rst_t = 1'b1, m_en_t = 1'b0, m_valid = 1'b0, m_tout = 1'b0;
  int m_fseg = 0, m_fmin = 0;
  bit [2:0] m_deb = '0, m_pulse = '0;
  int m_run [3];
  bit [2:0] m_hist [$];

  task automatic model_step();
    bit [2:0] v;
    int el;
    if (reset) begin
      m_state = 0; m_rst_t = 1'b1; m_en_t = 1'b0; m_valid = 1'b0; m_tout = 1'b0;
      m_fseg = 0; m_fmin = 0; m_deb = '0; m_pulse = '0;
      m_hist = '{3'b000, 3'b000};
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      el = int'(t_min) * 60 + int'(t_seg);
      if (m_pulse[0]) begin
        m_state = 1; m_valid = 1'b0; m_tout = 1'b0;
      end else if (m_state == 1 && m_pulse[1]) begin
        m_state = 2;
      end else if (m_state == 2 && int'(t_min) == TIMEOUT_MIN && t_seg == 0) begin
        m_state = 3; m_tout = 1'b1; m_valid = 1'b1; m_fseg = int'(t_seg); m_fmin = int'(t_min);
      end else if (m_state == 2 && m_pulse[2] && el >= MIN_LAP_S) begin
        m_state = 3; m_tout = 1'b0; m_valid = 1'b1; m_fseg = int'(t_seg); m_fmin = int'(t_min);
      end
      m_rst_t = (m_state <= 1);
      m_en_t  = (m_state == 2);
      // Input seen by the debouncer this edge is the raw level from two edges ago.
      v = m_hist.pop_front();
      m_hist.push_back({sensor_finish, sensor_start, btn_arm});
      m_pulse = '0;
      for (int i = 0; i < 3; i++) begin
        if (v[i] == m_deb[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DEB_CYC) begin
            m_deb[i] = v[i]; m_pulse[i] = v[i]; m_run[i] = 0;
          end
        end
      end
    end
  endtask

  // Stopwatch stand-in plus model, both advancing on the active edge.
  initial begin
    m_hist = '{3'b000, 3'b000};
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    forever begin
      @(posedge clk);
      if (reset || reset_timer) begin
        t_seg <= '0; t_min <= '0; t_tick <= 0;
      end else if (enable_timer) begin
        if (t_tick == TICK - 1) begin
          t_tick <= 0;
          if (t_seg == 6'd59) begin t_seg <= '0; t_min <= t_min + 4'd1; end
          else t_seg <= t_seg + 6'd1;
        end else t_tick <= t_tick + 1;
      end
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("model_estado", 32'(estado), 32'(m_state));
        chk("model_reset_timer", 32'(reset_timer), 32'(m_rst_t));
        chk("model_enable_timer", 32'(enable_timer), 32'(m_en_t));
        chk("model_final_seg", 32'(final_seg), 32'(m_fseg));
        chk("model_final_min", 32'(final_min), 32'(m_fmin));
        chk("model_final_valid", 32'(final_valid), 32'(m_valid));
        chk("model_timeout", 32'(timeout), 32'(m_tout));
      end
    end
  end

  task automatic apply(input logic [2:0] mask, input int hold, input int wait_c);
    {sensor_finish, sensor_start, btn_arm} = mask;
    repeat (hold) @(negedge clk);
    {sensor_finish, sensor_start, btn_arm} = 3'b000;
    repeat (wait_c) @(negedge clk);
  endtask

  task automatic wait_time(input int s, input int m, input int budget);
    int n;
    n = 0;
    while (!(int'(t_seg) == s && int'(t_min) == m) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_timer: timer never reached %0d:%02d within %0d cycles", m, s, budget);
    end
  endtask

  typedef struct {
    logic [2:0] mask;
    int         hold;
    int         wait_c;
    logic [1:0] st;
    logic       valid;
    logic       tout;
  } step_t;

  step_t tbl [15];

  initial begin
    tbl[0]  = '{3'b001, 12, 5,   2'd1, 1'b0, 1'b0};  // arm
    tbl[1]  = '{3'b010, 5,  20,  2'd1, 1'b0, 1'b0};  // start glitch rejected
    tbl[2]  = '{3'b100, 12, 5,   2'd1, 1'b0, 1'b0};  // finish while armed dropped
    tbl[3]  = '{3'b010, 12, 5,   2'd2, 1'b0, 1'b0};  // start
    tbl[4]  = '{3'b010, 12, 5,   2'd2, 1'b0, 1'b0};  // start outside ARMED ignored
    tbl[5]  = '{3'b100, 5,  20,  2'd2, 1'b0, 1'b0};  // finish glitch rejected
    tbl[6]  = '{3'b000, 0,  100, 2'd2, 1'b0, 1'b0};
    tbl[7]  = '{3'b100, 12, 5,   2'd3, 1'b1, 1'b0};  // finish after lockout
    tbl[8]  = '{3'b010, 12, 5,   2'd3, 1'b1, 1'b0};  // sensors ignored in DONE
    tbl[9]  = '{3'b001, 5,  20,  2'd3, 1'b1, 1'b0};  // arm glitch rejected
    tbl[10] = '{3'b011, 12, 5,   2'd1, 1'b0, 1'b0};  // arm + start together: arm wins
    tbl[11] = '{3'b000, 0,  20,  2'd1, 1'b0, 1'b0};  // start not queued
    tbl[12] = '{3'b010, 12, 5,   2'd2, 1'b0, 1'b0};
    tbl[13] = '{3'b000, 0,  40,  2'd2, 1'b0, 1'b0};
    tbl[14] = '{3'b001, 12, 5,   2'd1, 1'b0, 1'b0};  // arm mid-race

    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_reset_timer", 32'(reset_timer), 32'd1);
    chk("rst_enable_timer", 32'(enable_timer), 32'd0);
    chk("rst_final_valid", 32'(final_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_final_seg", 32'(final_seg), 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Pulse lands DEB_CYC+2 edges after the raw rise; state follows one edge later.
    btn_arm = 1'b1;
    repeat (DEB_CYC + 2) @(negedge clk);
    chk("arm_latency_before", 32'(estado), 32'd0);
    @(negedge clk);
    chk("arm_latency_after", 32'(estado), 32'd1);
    btn_arm = 1'b0;
    repeat (15) @(negedge clk);

    // Lockout: finish at 0:01 ignored, finish at 0:04 accepted.
    apply(3'b010, 12, 3);
    chk("start_running", 32'(estado), 32'd2);
    wait_time(1, 0, 200);
    apply(3'b100, 12, 3);
    chk("lockout_estado", 32'(estado), 32'd2);
    wait_time(4, 0, 200);
    apply(3'b100, 12, 3);
    chk("lap4_estado", 32'(estado), 32'd3);
    chk("lap4_final_seg", 32'(final_seg), 32'd4);
    chk("lap4_final_min", 32'(final_min), 32'd0);
    chk("lap4_valid", 32'(final_valid), 32'd1);
    chk("lap4_timeout", 32'(timeout), 32'd0);
    chk("lap4_enable", 32'(enable_timer), 32'd0);
    chk("lap4_reset_timer", 32'(reset_timer), 32'd0);

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].mask, tbl[i].hold, tbl[i].wait_c);
      chk($sformatf("tbl%0d_estado", i), 32'(estado), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_valid", i), 32'(final_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].tout));
    end

    // Race finished at 0:05.
    apply(3'b010, 12, 3);
    wait_time(5, 0, 300);
    apply(3'b100, 12, 3);
    chk("lap5_estado", 32'(estado), 32'd3);
    chk("lap5_final_seg", 32'(final_seg), 32'd5);
    chk("lap5_final_min", 32'(final_min), 32'd0);
    chk("lap5_valid", 32'(final_valid), 32'd1);

    // Timeout at 9:00 with the timer frozen afterwards.
    apply(3'b001, 12, 5);
    apply(3'b010, 12, 5);
    wait_time(0, TIMEOUT_MIN, 12000);
    repeat (3) @(negedge clk);
    chk("tmo_estado", 32'(estado), 32'd3);
    chk("tmo_timeout", 32'(timeout), 32'd1);
    chk("tmo_final_min", 32'(final_min), 32'd9);
    chk("tmo_final_seg", 32'(final_seg), 32'd0);
    chk("tmo_valid", 32'(final_valid), 32'd1);
    apply(3'b100, 12, 100);
    chk("tmo_frozen_min", 32'(t_min), 32'd9);
    chk("tmo_frozen_seg", 32'(t_seg), 32'd0);
    chk("tmo_still_timeout", 32'(timeout), 32'd1);

    // Reset mid-race clears the previous result.
    apply(3'b001, 12, 5);
    apply(3'b010, 12, 30);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_estado", 32'(estado), 32'd0);
    chk("midrst_final_min", 32'(final_min), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    chk("midrst_reset_timer", 32'(reset_timer), 32'd1);
    chk("midrst_enable", 32'(enable_timer), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      logic [2:0] mask;
      mask = 3'($urandom_range(0, 7)) & 3'b110;
      if ($urandom_range(0, 9) == 0) mask[0] = 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      apply(mask, $urandom_range(1, 25), $urandom_range(0, 40));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
